// File: rtl/scl_pattern_gen.sv
// Raster timing and RGB888 test-pattern source for the scaler input port.
// A two-state FSM (IDLE/RUN) walks an h/v counter pair over the full raster;
// every stream output is registered from the counter state, so each output
// slot trails its counter position by one clock. A frame always runs to its
// last slot once started; pattern select and frame-fill value are captured
// only at frame start.
module scl_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk_scl,
    input  logic       rst_n_scl,
    input  logic       pg_enable,
    input  logic [1:0] pg_pattern,
    output logic       scl_i_vsync,
    output logic       scl_i_hsync,
    output logic       scl_i_data_en,
    output logic [7:0] scl_i_data_r,
    output logic [7:0] scl_i_data_g,
    output logic [7:0] scl_i_data_b,
    output logic       pg_busy,
    output logic       pg_frame_done,
    output logic [7:0] pg_frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The horizontal counter is at least 8 bits so the ramp can use x[7:0]
    // directly; the vertical counter is at least 4 bits for the checker y[3].
    localparam int HW_RAW = $clog2(H_TOTAL);
    localparam int HW     = (HW_RAW < 8) ? 8 : HW_RAW;
    localparam int VW_RAW = $clog2(V_TOTAL);
    localparam int VW     = (VW_RAW < 4) ? 4 : VW_RAW;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Width of one colour bar; H_ACTIVE is a multiple of 8, so bars are equal.
    localparam int BAR_W = H_ACTIVE / 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_h;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] r_v;
    logic [VW-1:0] w_v_nxt;
    logic [1:0]    r_pattern;
    logic [1:0]    w_pattern_nxt;
    logic [7:0]    r_fill;
    logic [7:0]    w_fill_nxt;
    logic [7:0]    r_frame_cnt;
    logic [7:0]    w_frame_cnt_nxt;

    logic          w_run;
    logic          w_last;
    logic          w_de;
    logic          w_hs;
    logic          w_vs;
    logic          w_done;
    logic [2:0]    w_bar_idx;
    logic [7:0]    w_r;
    logic [7:0]    w_g;
    logic [7:0]    w_b;

    logic          r_vsync;
    logic          r_hsync;
    logic          r_de;
    logic [7:0]    r_r;
    logic [7:0]    r_g;
    logic [7:0]    r_b;
    logic          r_done;

    assign w_run  = (r_state == S_RUN);
    assign w_last = w_run && (r_h == H_LAST) && (r_v == V_LAST);

    // State, raster counters and per-frame captured settings.
    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            r_state     <= S_IDLE;
            r_h         <= '0;
            r_v         <= '0;
            r_pattern   <= 2'd0;
            r_fill      <= 8'd0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_h         <= w_h_nxt;
            r_v         <= w_v_nxt;
            r_pattern   <= w_pattern_nxt;
            r_fill      <= w_fill_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    // Next-state logic: start on enable, advance the raster, decide at the last slot.
    always_comb begin
        w_state_nxt     = r_state;
        w_h_nxt         = r_h;
        w_v_nxt         = r_v;
        w_pattern_nxt   = r_pattern;
        w_fill_nxt      = r_fill;
        w_frame_cnt_nxt = r_frame_cnt;
        case (r_state)
            S_IDLE: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (pg_enable) begin
                    w_state_nxt   = S_RUN;
                    w_pattern_nxt = pg_pattern;
                    w_fill_nxt    = r_frame_cnt;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    // Frame boundary: count it, then either roll straight into
                    // the next frame or stop; counters return to (0,0) either way.
                    w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                    w_h_nxt         = '0;
                    w_v_nxt         = '0;
                    if (pg_enable) begin
                        w_state_nxt   = S_RUN;
                        w_pattern_nxt = pg_pattern;
                        w_fill_nxt    = r_frame_cnt + 8'd1;
                    end else begin
                        w_state_nxt   = S_IDLE;
                    end
                end else if (r_h == H_LAST) begin
                    w_h_nxt = '0;
                    w_v_nxt = r_v + {{(VW-1){1'b0}}, 1'b1};
                end else begin
                    w_h_nxt = r_h + {{(HW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_h_nxt     = '0;
                w_v_nxt     = '0;
            end
        endcase
    end

    // Raster qualifiers for the slot the counters currently address.
    always_comb begin
        w_de   = w_run && (r_h < H_ACT_END) && (r_v < V_ACT_END);
        w_hs   = w_run && (r_h >= HS_BEG) && (r_h < HS_END);
        w_vs   = w_run && (r_v >= VS_BEG) && (r_v < VS_END);
        w_done = w_last;
    end

    // Colour-bar index: number of bar boundaries already passed on this line.
    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_h >= HW'(k * BAR_W)) begin
                w_bar_idx = w_bar_idx + 3'd1;
            end else begin
                w_bar_idx = w_bar_idx;
            end
        end
    end

    // Pixel colour for the selected pattern; black outside the active area.
    always_comb begin
        w_r = 8'h00;
        w_g = 8'h00;
        w_b = 8'h00;
        if (w_de) begin
            case (r_pattern)
                2'd0: begin
                    w_r = {8{~w_bar_idx[1]}};
                    w_g = {8{~w_bar_idx[2]}};
                    w_b = {8{~w_bar_idx[0]}};
                end
                2'd1: begin
                    w_r = r_h[7:0];
                    w_g = r_h[7:0];
                    w_b = r_h[7:0];
                end
                2'd2: begin
                    w_r = {8{r_h[3] ^ r_v[3]}};
                    w_g = {8{r_h[3] ^ r_v[3]}};
                    w_b = {8{r_h[3] ^ r_v[3]}};
                end
                2'd3: begin
                    w_r = r_fill;
                    w_g = ~r_fill;
                    w_b = 8'h00;
                end
                default: begin
                    w_r = 8'h00;
                    w_g = 8'h00;
                    w_b = 8'h00;
                end
            endcase
        end else begin
            w_r = 8'h00;
            w_g = 8'h00;
            w_b = 8'h00;
        end
    end

    // Output stage: one clock behind the counters.
    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_de    <= 1'b0;
            r_r     <= 8'h00;
            r_g     <= 8'h00;
            r_b     <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_vsync <= w_vs;
            r_hsync <= w_hs;
            r_de    <= w_de;
            r_r     <= w_r;
            r_g     <= w_g;
            r_b     <= w_b;
            r_done  <= w_done;
        end
    end

    assign scl_i_vsync   = r_vsync;
    assign scl_i_hsync   = r_hsync;
    assign scl_i_data_en = r_de;
    assign scl_i_data_r  = r_r;
    assign scl_i_data_g  = r_g;
    assign scl_i_data_b  = r_b;
    assign pg_busy       = w_run;
    assign pg_frame_done = r_done;
    assign pg_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_scl_pattern_gen.sv
// Bench for scl_pattern_gen: a frame-position model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_scl_pattern_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4,  VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 7
    localparam int FT = HT * VT;             // 168

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] pat = 2'd0;

    logic       vs, hs, de, busy, done;
    logic [7:0] r, g, b, fcnt;
    logic       c_vs, c_hs, c_de, c_busy, c_done;
    logic [7:0] c_r, c_g, c_b, c_fcnt;

    always #5 clk = ~clk;

    scl_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk_scl(clk), .rst_n_scl(rst_n), .pg_enable(en), .pg_pattern(pat),
        .scl_i_vsync(vs), .scl_i_hsync(hs), .scl_i_data_en(de),
        .scl_i_data_r(r), .scl_i_data_g(g), .scl_i_data_b(b),
        .pg_busy(busy), .pg_frame_done(done), .pg_frame_cnt(fcnt)
    );

    // Taller raster so the checker's second cell row (line 8) exists.
    scl_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(9), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_tall (
        .clk_scl(clk), .rst_n_scl(rst_n), .pg_enable(en), .pg_pattern(pat),
        .scl_i_vsync(c_vs), .scl_i_hsync(c_hs), .scl_i_data_en(c_de),
        .scl_i_data_r(c_r), .scl_i_data_g(c_g), .scl_i_data_b(c_b),
        .pg_busy(c_busy), .pg_frame_done(c_done), .pg_frame_cnt(c_fcnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bar colours in screen order: white, yellow, cyan, green, magenta, red, blue, black.
    logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    // Hand-written expectation for the 16 pixels of a bars line (2 pixels per bar).
    logic [23:0] bars_lit [16] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                                   24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'h00FF00,
                                   24'hFF00FF, 24'hFF00FF, 24'hFF0000, 24'hFF0000,
                                   24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000};

    // ---------------- model: generator position as a flat frame index ----------
    bit         m_run  = 1'b0;
    int         m_pos  = 0;       // position the generator addresses now
    logic [1:0] m_pat  = 2'd0;
    logic [7:0] m_fill = 8'd0;
    logic [7:0] m_cnt  = 8'd0;
    int         o_pos  = -1;      // position shown on the outputs (-1: blank)
    logic [1:0] o_pat  = 2'd0;
    logic [7:0] o_fill = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_pos <= 0; m_pat <= 2'd0; m_fill <= 8'd0; m_cnt <= 8'd0;
            o_pos <= -1; o_pat <= 2'd0; o_fill <= 8'd0;
        end else begin
            o_pos  <= m_run ? m_pos : -1;
            o_pat  <= m_pat;
            o_fill <= m_fill;
            if (!m_run) begin
                if (en) begin
                    m_run <= 1'b1; m_pos <= 0; m_pat <= pat; m_fill <= m_cnt;
                end
            end else if (m_pos == FT - 1) begin
                m_cnt <= m_cnt + 8'd1;
                m_pos <= 0;
                if (en) begin
                    m_pat <= pat; m_fill <= m_cnt + 8'd1;
                end else begin
                    m_run <= 1'b0;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    // Expected {vsync,hsync,de,rgb,busy,done,cnt} for a displayed position.
    function automatic logic [36:0] model_out(input int pos, input logic [1:0] p,
                                              input logic [7:0] fill, input bit run,
                                              input logic [7:0] cnt);
        int x, y;
        bit e_de, e_hs, e_vs, e_done;
        logic [23:0] rgb;
        logic [7:0] x8;
        if (pos < 0) return {3'b000, 24'h000000, run, 1'b0, cnt};
        x = pos % HT;
        y = pos / HT;
        x8 = 8'(x);
        e_de = (x < HA) && (y < VA);
        e_hs = (x >= HA + HF) && (x < HA + HF + HS);
        e_vs = (y >= VA + VF) && (y < VA + VF + VS);
        e_done = (pos == FT - 1);
        rgb = 24'h000000;
        if (e_de) begin
            case (p)
                2'd0: rgb = bar_col[x / (HA / 8)];
                2'd1: rgb = {x8, x8, x8};
                2'd2: rgb = (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
                default: rgb = {fill, ~fill, 8'h00};
            endcase
        end
        return {e_vs, e_hs, e_de, rgb, run, e_done, cnt};
    endfunction

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        chk("stream", {vs, hs, de, r, g, b, busy, done, fcnt},
            model_out(o_pos, o_pat, o_fill, m_run, m_cnt));
    end

    // ---------------- directed scenarios -----------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0; en = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the negedge where output slot 0 is on the pins.
    task automatic start(input logic [1:0] p);
        pat = p; en = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int de_n, hs_n, vs_n, first_hs, first_vs, done_n;
        logic [7:0] k8;

        // Reset state
        repeat (3) tick();
        chk("reset_out", {vs, hs, de, r, g, b, busy, done, fcnt}, 37'd0);
        #2 rst_n = 1'b1;
        tick();

        // Raster timing and colour bars over two frames
        start(2'd0);
        de_n = 0; hs_n = 0; vs_n = 0; done_n = 0; first_hs = -1; first_vs = -1;
        for (int i = 0; i < 2 * FT; i++) begin
            if (de) de_n++;
            if (hs) hs_n++;
            if (vs) vs_n++;
            if (done) done_n++;
            if (hs && first_hs < 0) first_hs = i;
            if (vs && first_vs < 0) first_vs = i;
            if (i < 16) chk("bars_px", {de, r, g, b}, {1'b1, bars_lit[i]});
            if (i >= 16 && i < HT) chk("rgb_blank", {de, r, g, b}, 25'd0);
            if (i == FT - 1) chk("done_f1", {done, fcnt}, {1'b1, 8'd1});
            if (i == 2 * FT - 1) chk("done_f2", {done, fcnt}, {1'b1, 8'd2});
            tick();
        end
        chk("de_count", de_n, 128);
        chk("hs_count", hs_n, 42);
        chk("vs_count", vs_n, 48);
        chk("hs_first", first_hs, 18);
        chk("vs_first", first_vs, 120);
        chk("done_count", done_n, 2);

        // Ramp
        do_reset();
        start(2'd1);
        for (int i = 0; i < 16; i++) begin
            k8 = 8'(i);
            chk("ramp", {de, r, g, b}, {1'b1, k8, k8, k8});
            tick();
        end

        // Checker (line 8 observed on the taller instance)
        do_reset();
        start(2'd2);
        for (int i = 0; i < 200; i++) begin
            if (i == 0) chk("chk_main_x0", {de, r, g, b}, {1'b1, 24'h000000});
            if (i == 8) chk("chk_main_x8", {de, r, g, b}, {1'b1, 24'hFFFFFF});
            if (i >= 8 && i < 16) chk("chk_l0", {c_de, c_r, c_g, c_b}, {1'b1, 24'hFFFFFF});
            if (i == 192) chk("chk_l8_x0", {c_de, c_r, c_g, c_b, c_hs, c_vs, c_done, c_busy, c_fcnt},
                              {1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0});
            if (i >= 200 && i < 208) chk("chk_l8", {c_de, c_r, c_g, c_b}, {1'b1, 24'h000000});
            tick();
        end
        for (int i = 200; i < 208; i++) begin
            chk("chk_l8", {c_de, c_r, c_g, c_b}, {1'b1, 24'h000000});
            tick();
        end

        // Mid-frame pattern change and disable
        do_reset();
        start(2'd0);
        for (int i = 0; i < FT + 20; i++) begin
            if (i == 48) begin pat = 2'd1; en = 1'b0; end
            if (i >= 48 && i < FT && de) chk("bars_hold", {r, g, b}, bars_lit[i % HT]);
            if (i == FT - 2) chk("busy_before_end", busy, 1'b1);
            if (i == FT - 1) chk("stop_last", {busy, done, fcnt}, {1'b0, 1'b1, 8'd1});
            if (i >= FT) chk("stopped", {vs, hs, de, r, g, b, busy, done}, 29'd0);
            tick();
        end

        // Enable low at the last slot, high again one cycle later
        do_reset();
        start(2'd0);
        for (int i = 0; i < FT + 4; i++) begin
            if (i == FT - 2) en = 1'b0;
            if (i == FT - 1) begin
                chk("gap_last", {busy, done}, 2'b01);
                en = 1'b1;
            end
            if (i == FT) chk("gap_idle", {busy, de}, 2'b10);
            if (i == FT + 1) chk("gap_restart", {busy, de, r, g, b, fcnt},
                                 {1'b1, 1'b1, 24'hFFFFFF, 8'd1});
            tick();
        end

        // Frame fill across 256 frames and counter wrap
        do_reset();
        start(2'd3);
        for (int i = 0; i < 256 * FT; i++) begin
            if (i % FT == 0) begin
                k8 = 8'(i / FT);
                chk("fill", {de, r, g, b}, {1'b1, k8, ~k8, 8'h00});
            end
            if (i == 255 * FT - 1) chk("cnt_255", {done, fcnt}, {1'b1, 8'd255});
            if (i == 256 * FT - 1) chk("cnt_wrap", {done, fcnt}, {1'b1, 8'd0});
            tick();
        end
        en = 1'b0;

        // Reset mid-frame at counter position h=5, v=2
        do_reset();
        start(2'd0);
        for (int i = 0; i < 52; i++) tick();
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {vs, hs, de, r, g, b, busy, done, fcnt}, 37'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("rst_rel_e1", {busy, de}, 2'b10);
        tick();
        chk("rst_rel_e2", {busy, de, r, g, b, fcnt}, {1'b1, 1'b1, 24'hFFFFFF, 8'd0});
        en = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
